avr_address_generator: RTL
==========================

# avr_address_generator

Downstream consumer of the AVR command decoder's strobe outputs. Builds the cartridge SRAM address from the serial shift-register controls (`avr_sreg_en_n`, `avr_si`), auto-increments it on `avr_counter_n` strobes, and drives the SRAM address and read/write strobes. In SNES mode, the SNES bus address and strobes pass through to the SRAM instead.

## Interface
Parameters:
- `ADDR_W`, default 24: SRAM address width; also the shift-register length.

Ports:
- `avr_clk`  in  1  system clock; all state updates on the rising edge.
- `avr_reset_n`  in  1  asynchronous, active-low reset.
- `avr_sreg_en_n`  in  1  low = shift enabled.
- `avr_si`  in  1  serial address bit, MSB first.
- `avr_counter_n`  in  1  each falling edge (sampled) increments the address.
- `avr_we_n`, `avr_oe_n`  in  1  AVR-side SRAM strobes.
- `avr_snes_mode`  in  1  1 = SNES owns the SRAM.
- `snes_addr`  in  ADDR_W  SNES bus address.
- `snes_we_n`, `snes_oe_n`  in  1  SNES strobes.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_we_n`, `sram_oe_n`  out  1  SRAM strobes.
- `addr_valid`  out  1  the AVR address was loaded from a complete `ADDR_W`-bit shift.
- `sreg_so`  out  1  MSB of the shift register (daisy-chain and readback).

## Operation
- All inputs are synchronous to `avr_clk`. There are no synchronizers. Edges are detected against one registered copy of each input.
- Shift: each cycle with `avr_sreg_en_n`=0, `shreg <= {shreg[ADDR_W-2:0], avr_si}`. `bitcnt` increments and saturates at `ADDR_W`.
- Load: rising edge of `avr_sreg_en_n`, i.e. the previous sample was 0 and the current sample is 1.
  - `addr_reg <= shreg`.
  - `addr_valid <= (bitcnt == ADDR_W)`.
  - `bitcnt <= 0`.
- More than `ADDR_W` shifts keep only the last `ADDR_W` bits. This still counts as valid.
- Increment: falling edge of `avr_counter_n` sets `addr_reg <= addr_reg + 1`, modulo 2^ADDR_W. All-ones wraps to 0, and `addr_valid` is unchanged.
- Simultaneous load and increment edges: the load wins and the increment is dropped.
- Increment while shifting (`avr_sreg_en_n`=0) is applied to `addr_reg`. The shifting itself is unaffected.
- State machine `st`:
  - **IDLE**: `avr_sreg_en_n`=1 and no shift since the last load.
  - **SHIFT**: entered on the first cycle with `avr_sreg_en_n`=0.
  - **LOADED**: entered on the load edge.
  - LOADED returns to SHIFT on the next `avr_sreg_en_n`=0.
  - Reset returns to IDLE.
- While in SHIFT:
  - `addr_valid` is forced to 0.
  - AVR strobes to the SRAM are blocked: `sram_we_n` and `sram_oe_n` stay 1.
- AVR mode (`avr_snes_mode`=0):
  - `sram_addr = addr_reg`.
  - `sram_we_n = avr_we_n_q | ~addr_valid`.
  - `sram_oe_n = avr_oe_n_q | ~addr_valid`.
- SNES mode (`avr_snes_mode`=1):
  - `sram_addr`, `sram_we_n` and `sram_oe_n` are combinational pass-through of `snes_addr`, `snes_we_n` and `snes_oe_n`.
  - Increments are ignored.
  - Shifting and loading continue, so the AVR can pre-stage an address.
- Mode switch takes effect in the same cycle (combinational mux). Never drive both SRAM strobes low from the AVR path: if `avr_we_n_q` and `avr_oe_n_q` are both 0, `sram_oe_n` is forced to 1.
- Reset mid-shift: the partial `shreg` is discarded.

## Timing
- Reset values:
  - `shreg` = 0, `bitcnt` = 0, `addr_reg` = 0, `st` = IDLE.
  - `addr_valid` = 0, `sreg_so` = 0.
  - `sram_we_n` = 1, `sram_oe_n` = 1, `sram_addr` = 0 (in AVR mode).
- Shift: a bit sampled at edge N appears in `shreg` after edge N. `sreg_so` is valid after edge N.
- Load: `avr_sreg_en_n` is seen high at edge N, and `sram_addr` and `addr_valid` update after edge N. That is one cycle of latency from the first high sample.
- Increment: `avr_counter_n` is seen low at edge N (previous sample high), and `sram_addr` updates after edge N.
- AVR strobes are registered for one cycle of latency. SNES path has zero latency.

## Structure
- Shared package `avr_pkg` holds:
  - The `ADDR_W` default.
  - The state encoding `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_LOADED`=2'd2.
- Sub-module `edge_detect` (registered input, `rise` and `fall` outputs). It is instantiated three times: `avr_sreg_en_n`, `avr_counter_n`, and the strobe register.
- Top holds the shift register, address counter, FSM and output mux.

## Test plan
- **Reset:** assert `avr_reset_n`=0 mid-shift after 10 bits -> all outputs return to reset values immediately, with no clock needed. After release, `addr_valid`=0 and `sram_addr`=0.
- **Full shift:** shift 24 bits of 0x12_3456 MSB first, then raise `avr_sreg_en_n` -> one cycle later `sram_addr`=0x123456 and `addr_valid`=1. Then `avr_oe_n`=0 -> `sram_oe_n`=0 the next cycle.
- **Partial and over-length shift:**
  - 20 bits then load -> `addr_valid`=0, and `avr_we_n`=0 keeps `sram_we_n`=1.
  - 28 bits ending in 0xABCDEF -> `sram_addr`=0xABCDEF and `addr_valid`=1.
- **Increment and wrap:** load 0xFFFFFE, then pulse `avr_counter_n` twice -> `sram_addr`=0xFFFFFF, then 0x000000, with `addr_valid` still 1. A load edge and a counter edge in the same cycle -> the loaded value, not incremented.
- **SNES mode:** set `avr_snes_mode`=1 with `snes_addr`=0x7E0010 and `snes_we_n`=0 -> same-cycle `sram_addr`=0x7E0010 and `sram_we_n`=0. `avr_counter_n` pulses are ignored. After returning to AVR mode, `sram_addr` equals the `addr_reg` value from before the switch.
- **Strobe conflict:** in AVR mode with `addr_valid`=1, drive `avr_we_n`=0 and `avr_oe_n`=0 together -> `sram_we_n`=0 and `sram_oe_n`=1.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared definitions for the AVR-side SRAM address generator: default
// address width and the shift/load state encoding.
package avr_pkg;

  localparam int ADDR_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LOADED = 2'd2
  } st_e;

endpackage : avr_pkg

// File: rtl/avr_address_generator_if.sv
// AVR control, SNES bus and SRAM-side signals of the address generator.
// The master side drives the AVR/SNES inputs; the slave side is the generator.
interface avr_address_generator_if
  import avr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              avr_sreg_en_n;
  logic              avr_si;
  logic              avr_counter_n;
  logic              avr_we_n;
  logic              avr_oe_n;
  logic              avr_snes_mode;
  logic [ADDR_W-1:0] snes_addr;
  logic              snes_we_n;
  logic              snes_oe_n;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              addr_valid;
  logic              sreg_so;

  modport master (
    output avr_sreg_en_n, avr_si, avr_counter_n, avr_we_n, avr_oe_n,
           avr_snes_mode, snes_addr, snes_we_n, snes_oe_n,
    input  sram_addr, sram_we_n, sram_oe_n, addr_valid, sreg_so
  );

  modport slave (
    input  avr_sreg_en_n, avr_si, avr_counter_n, avr_we_n, avr_oe_n,
           avr_snes_mode, snes_addr, snes_we_n, snes_oe_n,
    output sram_addr, sram_we_n, sram_oe_n, addr_valid, sreg_so
  );

endinterface : avr_address_generator_if

// File: rtl/avr_address_generator_edge_detect.sv
// One-register edge detector: q_o is the previous sample, rise_o/fall_o
// compare the current input against it in the same cycle.
module edge_detect #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d_i;
    end
  end

  assign q_o    = d_q;
  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule : edge_detect

// File: rtl/avr_address_generator.sv
// Serial-loaded, auto-incrementing SRAM address generator with SNES bypass.
// The AVR shifts an address in MSB first, loads it on the enable rising edge.
module avr_address_generator
  import avr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    avr_clk,
  input  logic                    avr_reset_n,
  avr_address_generator_if.slave  bus
);

  localparam int              CNT_W    = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_W);

  logic [ADDR_W-1:0] shreg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  bitcnt_q;
  logic              valid_q;
  st_e               st_q;

  logic              load_edge;
  logic              incr_edge;
  logic [1:0]        strb_q;
  logic              en_q_unused;
  logic              en_fall_unused;
  logic              cnt_q_unused;
  logic              cnt_rise_unused;
  logic [1:0]        strb_rise_unused;
  logic [1:0]        strb_fall_unused;

  edge_detect #(.W(1), .RST_VAL(1'b1)) u_en_edge (
    .clk_i  (avr_clk),
    .rst_ni (avr_reset_n),
    .d_i    (bus.avr_sreg_en_n),
    .q_o    (en_q_unused),
    .rise_o (load_edge),
    .fall_o (en_fall_unused)
  );

  edge_detect #(.W(1), .RST_VAL(1'b1)) u_cnt_edge (
    .clk_i  (avr_clk),
    .rst_ni (avr_reset_n),
    .d_i    (bus.avr_counter_n),
    .q_o    (cnt_q_unused),
    .rise_o (cnt_rise_unused),
    .fall_o (incr_edge)
  );

  // strb_q = {we_n, oe_n}, the one-cycle registered AVR strobes
  edge_detect #(.W(2), .RST_VAL(2'b11)) u_strb_reg (
    .clk_i  (avr_clk),
    .rst_ni (avr_reset_n),
    .d_i    ({bus.avr_we_n, bus.avr_oe_n}),
    .q_o    (strb_q),
    .rise_o (strb_rise_unused),
    .fall_o (strb_fall_unused)
  );

  always_ff @(posedge avr_clk or negedge avr_reset_n) begin
    if (!avr_reset_n) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      st_q     <= ST_IDLE;
    end else begin
      if (!bus.avr_sreg_en_n) begin
        shreg_q <= {shreg_q[ADDR_W-2:0], bus.avr_si};
        if (bitcnt_q != CNT_FULL) begin
          bitcnt_q <= bitcnt_q + CNT_W'(1);
        end
        valid_q <= 1'b0;
        st_q    <= ST_SHIFT;
      end
      // Load beats a coincident increment; increments are SNES-gated.
      if (load_edge) begin
        addr_q   <= shreg_q;
        valid_q  <= (bitcnt_q == CNT_FULL);
        bitcnt_q <= '0;
        st_q     <= ST_LOADED;
      end else if (incr_edge && !bus.avr_snes_mode) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  logic avr_blk;
  logic avr_we_n;
  logic avr_oe_n;

  // oe is suppressed whenever we is active so the AVR never drives both low.
  assign avr_blk  = ~valid_q | (st_q == ST_SHIFT);
  assign avr_we_n = strb_q[1] | avr_blk;
  assign avr_oe_n = strb_q[0] | ~strb_q[1] | avr_blk;

  assign bus.sram_addr  = bus.avr_snes_mode ? bus.snes_addr : addr_q;
  assign bus.sram_we_n  = bus.avr_snes_mode ? bus.snes_we_n : avr_we_n;
  assign bus.sram_oe_n  = bus.avr_snes_mode ? bus.snes_oe_n : avr_oe_n;
  assign bus.addr_valid = valid_q;
  assign bus.sreg_so    = shreg_q[ADDR_W-1];

endmodule : avr_address_generator
